// File: rtl/sysctrl_host.sv
// Byte-stream initiator for the system-control link: frames command + payload
// onto the strobe bus, captures readback bytes, and services the parser interrupt.
module sysctrl_host #(
  parameter int GAP     = 3,
  parameter int MAX_LEN = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_cmd,
  input  logic [2:0]             req_len,
  input  logic [8*MAX_LEN-1:0]   req_payload,
  output logic                   rsp_valid,
  output logic [8*MAX_LEN-1:0]   rsp_data,
  output logic                   irq_valid,
  output logic [7:0]             irq_status,
  output logic                   bus_strobe,
  output logic                   bus_start,
  output logic [7:0]             bus_data,
  input  logic [7:0]             bus_rdata,
  input  logic                   int_n
);

  // state | meaning
  // IDLE  | arbitration: pending ack, new request, then interrupt line
  // CMD   | command byte strobe with bus_start
  // GAPW  | GAP quiet cycles; readback captured in the last one
  // DATA  | payload byte strobe
  // DONE  | completion pulse, back to IDLE next cycle
  typedef enum logic [2:0] {IDLE, CMD, GAPW, DATA, DONE} state_t;
  typedef enum logic [1:0] {PH_REQ, PH_IRQ_RD, PH_IRQ_ACK} phase_t;

  localparam int          PAY_W    = 8 * MAX_LEN;
  localparam logic [2:0]  LEN_MAX  = 3'(MAX_LEN);
  localparam logic [3:0]  GAP_LOAD = 4'(GAP - 1);
  localparam logic [7:0]  IRQ_CMD  = 8'h05;

  state_t           state, state_nxt;
  phase_t           phase;
  logic             ack_pend, pay_sent;
  logic [2:0]       len_q, idx, idx_nxt;
  logic [3:0]       gap_cnt;
  logic [PAY_W-1:0] payload_q;
  logic             start_req, start_irq, start_ack, gap_last, more;

  always_comb begin
    start_ack = (state == IDLE) && ack_pend;
    start_req = (state == IDLE) && !ack_pend && req_valid;
    start_irq = (state == IDLE) && !ack_pend && !req_valid && !int_n;
    gap_last  = (state == GAPW) && (gap_cnt == 4'd0);
    idx_nxt   = pay_sent ? idx + 3'd1 : idx;
    more      = idx_nxt < len_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus_strobe = 1'b0;
    bus_start  = 1'b0;
    rsp_valid  = 1'b0;
    irq_valid  = 1'b0;
    req_ready  = (state == IDLE) && !ack_pend && !reset;
    case (state)
      IDLE: if (start_ack || start_req || start_irq) state_nxt = CMD;
      CMD: begin
        bus_strobe = 1'b1;
        bus_start  = 1'b1;
        state_nxt  = GAPW;
      end
      DATA: begin
        bus_strobe = 1'b1;
        state_nxt  = GAPW;
      end
      GAPW: if (gap_cnt == 4'd0) state_nxt = more ? DATA : DONE;
      DONE: begin
        state_nxt = IDLE;
        rsp_valid = (phase == PH_REQ);
        // A zero status has nothing to acknowledge, so the read frame ends service
        irq_valid = (phase == PH_IRQ_ACK) || ((phase == PH_IRQ_RD) && (irq_status == 8'h00));
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= PH_REQ;
      ack_pend   <= 1'b0;
      pay_sent   <= 1'b0;
      len_q      <= 3'd0;
      idx        <= 3'd0;
      gap_cnt    <= 4'd0;
      payload_q  <= '0;
      bus_data   <= 8'h00;
      rsp_data   <= '0;
      irq_status <= 8'h00;
    end else begin
      if (start_ack) begin
        phase     <= PH_IRQ_ACK;
        len_q     <= 3'd1;
        payload_q <= PAY_W'(irq_status);
        bus_data  <= IRQ_CMD;
        ack_pend  <= 1'b0;
      end else if (start_req) begin
        phase     <= PH_REQ;
        len_q     <= (req_len > LEN_MAX) ? LEN_MAX : req_len;
        payload_q <= req_payload;
        bus_data  <= req_cmd;
      end else if (start_irq) begin
        phase     <= PH_IRQ_RD;
        len_q     <= 3'd1;
        payload_q <= '0;
        bus_data  <= IRQ_CMD;
      end

      if (state == IDLE) begin
        idx      <= 3'd0;
        pay_sent <= 1'b0;
      end

      if (state == CMD || state == DATA)  gap_cnt <= GAP_LOAD;
      else if (state == GAPW && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;

      if (gap_last) begin
        if (pay_sent) begin
          case (phase)
            PH_REQ:    rsp_data[{idx, 3'b000} +: 8] <= bus_rdata;
            PH_IRQ_RD: irq_status <= bus_rdata;
            default:   ;
          endcase
        end
        idx <= idx_nxt;
        if (more) begin
          bus_data <= payload_q[{idx_nxt, 3'b000} +: 8];
          pay_sent <= 1'b1;
        end
      end

      if (state == DONE && phase == PH_IRQ_RD && irq_status != 8'h00) ack_pend <= 1'b1;
    end
  end

endmodule
